// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one combinational memory read port between
// code fetch (requester 0) and data read (requester 1), with programmable wait states.
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0]            WAIT_CNT   = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH);

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;       // 1 = requester 1 preferred on a tie
  logic                  id_q, id_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [1:0]            grant_s;
  logic                  out_of_range_s;

  assign out_of_range_s = (mem_address_q >= DEPTH_ADDR);

  // Grant selection: only offered while idle, ties broken by the round-robin pointer
  always_comb begin
    grant_s = 2'b00;
    if (state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = rr_q ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Next-state and next-output computation for the IDLE/BUSY sequencer
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    rsp_valid_d   = 2'b00;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          id_d          = grant_s[1];
          mem_address_d = grant_s[1] ? req_addr1 : req_addr0;
          cnt_d         = WAIT_CNT;
          rr_d          = !grant_s[1];
          state_d       = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Out-of-range reads never expose whatever the memory model returns
          rsp_data_d  = out_of_range_s ? {DATA_WIDTH{1'b0}} : mem_read_data;
          rsp_error_d = out_of_range_s;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      id_q          <= 1'b0;
      cnt_q         <= 4'd0;
      mem_address_q <= {ADDR_WIDTH{1'b0}};
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= {DATA_WIDTH{1'b0}};
      rsp_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
    end
  end

  assign req_ready   = grant_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign mem_address = mem_address_q;
  assign busy        = (state_q == BUSY);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a cycle-level reference model predicts grants and
// pushes expected responses; an independent monitor pops and checks them.
module tb_memory_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int WS    = 1;

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  logic          clock;
  logic          reset;
  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, mem_read_data;
  logic          rsp_error, busy;
  logic [AW-1:0] mem_address;

  // second stimulus set for the WAIT_STATES=0 (z_) and WAIT_STATES=3 (t_) builds
  logic [1:0]    a_valid;
  logic [AW-1:0] a_addr;
  logic [1:0]    z_ready, z_rsp_valid, t_ready, t_rsp_valid;
  logic [DW-1:0] z_rsp_data, z_mem_rd, t_rsp_data, t_mem_rd;
  logic          z_rsp_error, z_busy, t_rsp_error, t_busy;
  logic [AW-1:0] z_mem_address, t_mem_address;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   acc_cnt[2];
  int   iss_cnt[2];
  logic end_req = 1'b0;

  // memory contents: in range words are 0x1000_0000+n, the rest is junk
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a < AW'(DEPTH)) return 32'h1000_0000 + a;
    else return 32'hDEAD_BEEF;
  endfunction

  assign mem_read_data = mem_word(mem_address);
  assign z_mem_rd      = mem_word(z_mem_address);
  assign t_mem_rd      = mem_word(t_mem_address);

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr0(req_addr0),
    .req_addr1(req_addr1), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .mem_address(mem_address), .mem_read_data(mem_read_data), .busy(busy));

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .req_valid(a_valid), .req_addr0(a_addr),
    .req_addr1(a_addr), .req_ready(z_ready), .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data),
    .rsp_error(z_rsp_error), .mem_address(z_mem_address), .mem_read_data(z_mem_rd), .busy(z_busy));

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(reset), .req_valid(a_valid), .req_addr0(a_addr),
    .req_addr1(a_addr), .req_ready(t_ready), .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data),
    .rsp_error(t_rsp_error), .mem_address(t_mem_address), .mem_read_data(t_mem_rd), .busy(t_busy));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference model: who may be granted, when the port is free, what each accept returns
  initial begin : model
    int       busy_left;
    logic     rr;
    logic [AW-1:0] exp_addr;
    logic [1:0] exp_ready;
    exp_t     e;
    busy_left = 0;
    rr        = 1'b0;
    exp_addr  = '0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy_left = 0;
        rr        = 1'b0;
        exp_addr  = '0;
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].due >= cyc) sb.delete(i);
      end else begin
        chk("busy", 64'(busy), 64'(busy_left > 0));
        exp_ready = 2'b00;
        if (busy_left == 0)
          exp_ready = (req_valid == 2'b11) ? (rr ? 2'b10 : 2'b01) : req_valid;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("mem_address", 64'(mem_address), 64'(exp_addr));
        if (busy_left > 0) begin
          busy_left--;
        end else if (exp_ready != 2'b00) begin
          e.id   = exp_ready[1];
          e.addr = e.id ? req_addr1 : req_addr0;
          e.err  = (e.addr >= AW'(DEPTH));
          e.data = e.err ? 32'h0 : 32'h1000_0000 + e.addr;
          e.due  = cyc + 2 + WS;
          sb.push_back(e);
          busy_left = WS + 1;
          rr        = !e.id;
          exp_addr  = e.addr;
          acc_cnt[e.id]++;
        end
      end
    end
  end

  // response monitor: pops the scoreboard whenever the DUT presents a response
  initial begin : monitor
    logic [DW-1:0] hold_data;
    logic          hold_err;
    logic          end_done;
    exp_t          e;
    hold_data = '0;
    hold_err  = 1'b0;
    end_done  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_data = '0;
        hold_err  = 1'b0;
      end else if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(2'b00));
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(e.id ? 2'b10 : 2'b01));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_error", 64'(rsp_error), 64'(e.err));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          hold_data = e.data;
          hold_err  = e.err;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          chk("rsp_missing", 64'(cyc), 64'(sb[0].due));
          void'(sb.pop_front());
        end
        chk("rsp_data_hold", 64'(rsp_data), 64'(hold_data));
        chk("rsp_error_hold", 64'(rsp_error), 64'(hold_err));
      end
      if (end_req && !end_done) begin
        chk("sb_drained", 64'(sb.size()), 64'd0);
        end_done = 1'b1;
      end
    end
  end

  // latency checker for the zero and three wait-state builds
  initial begin : aux_check
    logic          active;
    int            t0, k;
    logic [AW-1:0] addr;
    active = 1'b0;
    t0     = 0;
    addr   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        active = 1'b0;
      end else if (!active && a_valid == 2'b01) begin
        chk("ws0_ready", 64'(z_ready), 64'(2'b01));
        chk("ws3_ready", 64'(t_ready), 64'(2'b01));
        t0     = cyc;
        addr   = a_addr;
        active = 1'b1;
      end else if (active) begin
        k = cyc - t0;
        chk("ws0_rsp_valid", 64'(z_rsp_valid), 64'((k == 2) ? 2'b01 : 2'b00));
        chk("ws3_rsp_valid", 64'(t_rsp_valid), 64'((k == 5) ? 2'b01 : 2'b00));
        chk("ws0_busy", 64'(z_busy), 64'(k == 1));
        chk("ws3_busy", 64'(t_busy), 64'(k >= 1 && k <= 4));
        chk("ws3_mem_address", 64'(t_mem_address), 64'(addr));
        if (k == 2) chk("ws0_rsp_data", 64'(z_rsp_data), 64'(32'h1000_0000 + addr));
        if (k == 5) chk("ws3_rsp_data", 64'(t_rsp_data), 64'(32'h1000_0000 + addr));
        if (k >= 7) active = 1'b0;
      end
    end
  end

  // one stimulus cycle; a requester with an unaccepted request keeps holding it
  task automatic tick(input logic rst, input logic [1:0] want,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(posedge clock);
    #1;
    reset = rst;
    if (iss_cnt[0] == acc_cnt[0]) begin
      if (want[0] && !rst) begin
        req_valid[0] = 1'b1;
        req_addr0    = a0;
        iss_cnt[0]++;
      end else begin
        req_valid[0] = 1'b0;
      end
    end
    if (iss_cnt[1] == acc_cnt[1]) begin
      if (want[1] && !rst) begin
        req_valid[1] = 1'b1;
        req_addr1    = a1;
        iss_cnt[1]++;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
  endtask

  task automatic aux_req(input logic [AW-1:0] a);
    @(posedge clock);
    #1;
    a_addr  = a;
    a_valid = 2'b01;
    @(posedge clock);
    #1;
    a_valid = 2'b00;
    repeat (9) @(posedge clock);
  endtask

  initial begin
    logic [AW-1:0] ra0, ra1;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    a_valid   = 2'b00;
    a_addr    = '0;
    iss_cnt[0] = 0;
    iss_cnt[1] = 0;
    repeat (3) tick(1'b1, 2'b00, 0, 0);
    // both requesters from reset release: alternate 0,1,0,1
    repeat (12) tick(1'b0, 2'b11, 3, 7);
    repeat (6) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b01, 5, 0);
    repeat (5) tick(1'b0, 2'b00, 0, 0);
    // out-of-range boundary and full-width unsigned compare
    tick(1'b0, 2'b10, 0, 32);
    repeat (3) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b10, 0, 31);
    repeat (4) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b01, 32'hFFFF_FFFF, 0);
    repeat (4) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b10, 0, 32'h8000_0000);
    repeat (4) tick(1'b0, 2'b00, 0, 0);
    // reset right after an accept drops the transaction and the RR pointer
    tick(1'b0, 2'b01, 9, 0);
    tick(1'b1, 2'b00, 0, 0);
    repeat (2) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b01, 9, 0);
    repeat (4) tick(1'b0, 2'b00, 0, 0);
    tick(1'b0, 2'b11, 1, 2);
    repeat (6) tick(1'b0, 2'b00, 0, 0);
    // requester 1 alone, back-to-back
    repeat (9) tick(1'b0, 2'b10, 0, 4);
    repeat (4) tick(1'b0, 2'b00, 0, 0);
    aux_req(0);
    aux_req(6);
    repeat (400) begin
      ra0 = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 40));
      ra1 = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 40));
      tick(1'b0, 2'($urandom_range(0, 3)), ra0, ra1);
    end
    repeat (12) tick(1'b0, 2'b00, 0, 0);
    end_req = 1'b1;
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single combinational read port of the simulation `memory` between two requesters: requester 0 is code fetch, requester 1 is data read.
- Arbitrates round-robin, sequences the memory address, and inserts programmable wait states.
- Returns registered read data with a per-requester response pulse.
- Sits between the core's fetch/load units and `memory` in the simulation top level.

Parameters:
- ADDR_WIDTH, 32, width of request and memory word addresses.
- DATA_WIDTH, 32, width of read data.
- DEPTH, 32, number of valid memory words; addresses >= DEPTH are out-of-range.
- WAIT_STATES, 1, extra cycles the address is held before data is sampled (0..15).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request (bit0 fetch, bit1 data).
- req_addr0  input  ADDR_WIDTH  requester 0 word address.
- req_addr1  input  ADDR_WIDTH  requester 1 word address.
- req_ready  output  2  per-requester accept strobe (one-hot or zero).
- rsp_valid  output  2  per-requester one-cycle response pulse.
- rsp_data  output  DATA_WIDTH  response data, valid with rsp_valid.
- rsp_error  output  1  out-of-range flag, valid with rsp_valid.
- mem_address  output  ADDR_WIDTH  address driven to `memory` read_address.
- mem_read_data  input  DATA_WIDTH  `memory` read_data (combinational).
- busy  output  1  high while a transaction is in flight.

Behaviour:
- Reset values: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, mem_address=0, busy=0, RR pointer = requester 0 preferred.
- States are IDLE and BUSY.
- **IDLE:**
  - req_ready is combinational: the granted bit is high iff state==IDLE and that requester's req_valid=1.
  - Grant rule:
    - only one valid -> grant it;
    - both valid -> grant the preferred one per the RR pointer.
  - An accept is a cycle with req_valid[i] & req_ready[i].
  - On accept: latch the address into mem_address, latch the requester id, load cnt=WAIT_STATES, flip the RR pointer to prefer the other requester, go to BUSY.
  - If no request, stay in IDLE; mem_address holds its last value.
- **BUSY:**
  - busy=1; mem_address is held constant; req_ready=0.
  - cnt>0 -> decrement.
  - cnt==0 -> at the clock edge:
    - capture rsp_data = mem_read_data, or 0 if the latched address >= DEPTH;
    - set rsp_error = (address >= DEPTH);
    - set rsp_valid[id]=1;
    - go to IDLE.
- Out-of-range check is an unsigned compare on the full ADDR_WIDTH.
- Latency:
  - accept in cycle T;
  - BUSY in cycles T+1 .. T+1+WAIT_STATES;
  - rsp_valid high in cycle T+2+WAIT_STATES for exactly one cycle.
- Throughput: one transaction per WAIT_STATES+2 cycles.
- rsp_valid is cleared the cycle after it is set.
- rsp_data and rsp_error hold until the next response.
- In the IDLE cycle where rsp_valid is high, a new accept may occur (back-to-back).
- req_valid deasserted while BUSY has no effect: the transaction completes.
- Requesters hold req_valid and req_addr until accepted. The address is sampled only in the accept cycle.
- Reset asserted mid-transaction: the transaction is dropped, no rsp_valid is issued, and all outputs return to reset values the cycle after.

Test Plan:
1. Bench preloads mem[n] = 32'h1000_0000+n, WAIT_STATES=1. Requester 0 requests addr 5 at cycle 2 -> req_ready=2'b01 at cycle 2, mem_address=5 in cycles 3-4, rsp_valid=2'b01 at cycle 5, rsp_data=32'h1000_0005, rsp_error=0.
2. Both requesters valid from reset release (addr0=3, addr1=7) -> grant order 0,1,0,1. Responses 32'h1000_0003 (rsp_valid bit0), 32'h1000_0007 (bit1), alternating every 3 cycles; the second accept occurs in the same cycle as the first rsp_valid.
3. Requester 1 requests addr 32 (DEPTH=32) -> rsp_valid=2'b10 after 3 cycles, rsp_data=0, rsp_error=1. A following request to addr 31 returns 32'h1000_001F with rsp_error=0.
4. WAIT_STATES=0 vs 3 build, single request to addr 0 -> rsp_valid at accept+2 and accept+5 respectively; mem_address stable throughout BUSY.
5. Requester 0 accepted with addr 9, reset asserted the next cycle for 1 cycle -> no rsp_valid ever seen for addr 9. The next request from requester 0 to addr 9 is granted (pointer reset) and returns 32'h1000_0009 normally.
6. Requester 1 alone, continuously valid with addr 4 -> granted every 3 cycles despite the RR pointer preferring requester 0. busy toggles 1,1,0 per transaction.
